// File: rtl/dmem_bridge.sv
// dmem_bridge: turns single-cycle core data requests into req/ack bus beats.
// Build option DMEM_MISALIGN_SPLIT_EN: serve misaligned accesses instead of flagging them.
module dmem_bridge #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            data_re,
    input  logic            data_we,
    input  logic [XLEN-1:0] data_addr,
    input  logic [1:0]      data_size,
    input  logic            data_unsigned,
    input  logic [XLEN-1:0] data_out,
    output logic [XLEN-1:0] data_in,
    output logic            stall,
    output logic            misaligned,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUS0, BUS1, RESP} state_t;

    state_t          state_q;
    logic            bus_req_q;
    logic            bus_we_q;
    logic [XLEN-1:0] bus_addr_q;
    logic [3:0]      bus_be_q;
    logic [XLEN-1:0] bus_wdata_q;
    logic [XLEN-1:0] data_in_q;
    logic            fault_q;
    logic            we_q;
    logic            uns_q;
    logic            cross_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic [3:0]      be_hi_q;
    logic [XLEN-1:0] wd_hi_q;
    logic [XLEN-1:0] rdata0_q;
    logic [23:0]     rdata1_q;

    logic            req;
    logic            fault;
    logic            crossing;
    logic [1:0]      off;
    logic [7:0]      mask;
    logic [7:0]      be8;
    logic [63:0]     wd64;
    logic [XLEN-1:0] ld32;
    logic [XLEN-1:0] load_val;

    assign req      = data_re | data_we;
    assign off      = data_addr[1:0];
    assign be8      = mask << off;
    assign wd64     = {32'b0, data_out} << {off, 3'b000};
    assign crossing = (be8[7:4] != 4'b0000);

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign fault = 1'b0;
`else
    assign fault = ((data_size == 2'b01) && off[0]) ||
                   (data_size[1] && (off != 2'b00));
`endif

    // Lane mask for the access width, before shifting to the byte offset
    always_comb begin
        mask = 8'h0F;
        case (data_size)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            default: mask = 8'h0F;
        endcase
    end

    // Right-justify the (possibly two-beat) read data and extend it
    always_comb begin
        ld32 = rdata0_q;
        case (off_q)
            2'd1:    ld32 = {rdata1_q[7:0], rdata0_q[31:8]};
            2'd2:    ld32 = {rdata1_q[15:0], rdata0_q[31:16]};
            2'd3:    ld32 = {rdata1_q[23:0], rdata0_q[31:24]};
            default: ld32 = rdata0_q;
        endcase
        load_val = ld32;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, ld32[7:0]}
                                      : {{24{ld32[7]}}, ld32[7:0]};
            2'b01:   load_val = uns_q ? {16'b0, ld32[15:0]}
                                      : {{16{ld32[15]}}, ld32[15:0]};
            default: load_val = ld32;
        endcase
    end

    // Pipeline freeze: request cycle plus every bus beat, never in reset
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:    stall = req;
                BUS0:    stall = 1'b1;
                BUS1:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    // Access FSM with registered bus outputs and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
            data_in_q   <= '0;
            fault_q     <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            cross_q     <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            be_hi_q     <= 4'b0000;
            wd_hi_q     <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= data_we;
                        uns_q   <= data_unsigned;
                        off_q   <= off;
                        size_q  <= data_size;
                        cross_q <= crossing;
                        be_hi_q <= be8[7:4];
                        wd_hi_q <= wd64[63:32];
                        if (fault) begin
                            fault_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= data_we;
                            bus_addr_q  <= {data_addr[31:2], 2'b00};
                            bus_be_q    <= be8[3:0];
                            bus_wdata_q <= wd64[31:0];
                            state_q     <= BUS0;
                        end
                    end
                end
                BUS0: begin
                    if (bus_ack) begin
                        rdata0_q <= bus_rdata;
                        if (cross_q) begin
                            bus_addr_q  <= bus_addr_q + 32'd4;
                            bus_be_q    <= be_hi_q;
                            bus_wdata_q <= wd_hi_q;
                            state_q     <= BUS1;
                        end else begin
                            bus_req_q <= 1'b0;
                            state_q   <= RESP;
                        end
                    end
                end
                BUS1: begin
                    if (bus_ack) begin
                        rdata1_q  <= bus_rdata[23:0];
                        bus_req_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                default: begin
                    fault_q <= 1'b0;
                    if (!we_q && !fault_q) begin
                        data_in_q <= load_val;
                    end
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_req    = bus_req_q & rst_n;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign data_in    = data_in_q;
    assign misaligned = fault_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: random loads/stores against a byte-level memory model,
// with a req/ack bus slave and scoreboards for bus beats and completions.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_re = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [1:0]  data_size = '0;
    logic        data_unsigned = 1'b0;
    logic [31:0] data_out = '0;
    logic [31:0] data_in;
    logic        stall;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    dmem_bridge #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_re(data_re), .data_we(data_we),
        .data_addr(data_addr), .data_size(data_size),
        .data_unsigned(data_unsigned), .data_out(data_out),
        .data_in(data_in), .stall(stall), .misaligned(misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        int          stalls;
        logic        mis;
        logic [31:0] din;
    } cmp_t;

    int n_checks = 0;
    int n_pass = 0;

    beat_t beat_q[$];
    cmp_t  cmp_q[$];
    int    wait_q[$];
    logic [31:0] exp_din = '0;

    logic [31:0] smem [logic [31:0]];
    logic [7:0]  bmem [logic [31:0]];

    bit mon_en = 1'b0;
    bit slave_en = 1'b1;
    bit have_beat = 1'b0;
    int wcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_checks++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    function automatic logic [31:0] winit(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] sread(input logic [31:0] wa);
        return smem.exists(wa) ? smem[wa] : winit(wa);
    endfunction

    function automatic logic [7:0] bread(input logic [31:0] a);
        logic [31:0] w;
        if (bmem.exists(a)) return bmem[a];
        w = winit({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic preset(input logic [31:0] wa, input logic [31:0] v);
        smem[wa] = v;
        for (int k = 0; k < 4; k++) bmem[wa + k] = v[8*k +: 8];
    endtask

    // Reference model + driver: one core access, held until stall drops
    task automatic do_req(input logic we, input logic both, input logic [1:0] sz,
                          input logic [31:0] addr, input logic uns,
                          input logic [31:0] wd, input int w0, input int w1);
        int nb;
        int nbeats;
        int n;
        int p;
        int k;
        bit mis;
        logic [31:0] a;
        logic [31:0] v;
        beat_t b[2];
        cmp_t c;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
        mis = 1'b0;
`else
        mis = (addr % nb) != 0;
`endif
        a = addr + nb - 1;
        nbeats = ({a[31:2], 2'b00} != {addr[31:2], 2'b00}) ? 2 : 1;
        for (int kk = 0; kk < 2; kk++) begin
            b[kk].addr = {addr[31:2], 2'b00} + 32'(4 * kk);
            b[kk].be = 4'b0000;
            b[kk].we = we;
            b[kk].wdata = '0;
            for (int j = 0; j < 4; j++) begin
                p = kk * 4 + j - int'(addr[1:0]);
                if (p >= 0 && p < 4) b[kk].wdata[8*j +: 8] = wd[8*p +: 8];
            end
        end
        for (int i = 0; i < nb; i++) begin
            a = addr + i;
            k = ({a[31:2], 2'b00} == b[0].addr) ? 0 : 1;
            b[k].be[a[1:0]] = 1'b1;
        end
        if (mis) begin
            c.stalls = 1;
            c.mis = 1'b1;
        end else begin
            beat_q.push_back(b[0]);
            wait_q.push_back(w0);
            c.stalls = 1 + (w0 + 1);
            if (nbeats == 2) begin
                beat_q.push_back(b[1]);
                wait_q.push_back(w1);
                c.stalls += w1 + 1;
            end
            c.mis = 1'b0;
            if (we) begin
                for (int i = 0; i < nb; i++) bmem[addr + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = bread(addr + i);
                if (!uns && nb < 4 && v[8*nb-1]) begin
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                exp_din = v;
            end
        end
        c.din = exp_din;
        cmp_q.push_back(c);
        data_we = we;
        data_re = !we || both;
        data_size = sz;
        data_addr = addr;
        data_unsigned = uns;
        data_out = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 60);
        if (stall) fail("request_timeout");
        @(posedge clk);
        #1;
        data_re = 1'b0;
        data_we = 1'b0;
        data_addr = $urandom;
        data_out = $urandom;
    endtask

    // Bus slave and beat monitor
    initial forever begin
        @(negedge clk);
        if (slave_en) begin
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (rst_n && bus_req) begin
                if (beat_q.size() == 0) begin
                    fail("bus_unexpected_beat");
                end else begin
                    chk("bus_addr", bus_addr, beat_q[0].addr);
                    chk("bus_be", {28'b0, bus_be}, {28'b0, beat_q[0].be});
                    chk("bus_we", {31'b0, bus_we}, {31'b0, beat_q[0].we});
                    if (beat_q[0].we) chk("bus_wdata", bus_wdata, beat_q[0].wdata);
                end
                if (!have_beat) begin
                    wcnt = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
                    have_beat = 1'b1;
                end
                if (wcnt == 0) begin
                    logic [31:0] w;
                    bus_ack = 1'b1;
                    have_beat = 1'b0;
                    w = sread(bus_addr);
                    if (bus_we) begin
                        for (int j = 0; j < 4; j++)
                            if (bus_be[j]) w[8*j +: 8] = bus_wdata[8*j +: 8];
                        smem[bus_addr] = w;
                    end else begin
                        bus_rdata = w;
                    end
                    if (beat_q.size() != 0) void'(beat_q.pop_front());
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Completion monitor: stall length, misaligned pulse, load result
    initial begin
        int   scount;
        bit   chk_din;
        cmp_t cur;
        scount = 0;
        chk_din = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                scount = 0;
                chk_din = 1'b0;
            end else begin
                if (chk_din) begin
                    chk("data_in", data_in, cur.din);
                    chk("misaligned_one_cycle", {31'b0, misaligned}, 32'd0);
                    chk_din = 1'b0;
                end
                if (stall) begin
                    scount++;
                end else if (scount > 0) begin
                    if (cmp_q.size() == 0) begin
                        fail("unexpected_completion");
                    end else begin
                        cur = cmp_q.pop_front();
                        chk("stall_cycles", scount, cur.stalls);
                        chk("misaligned", {31'b0, misaligned}, {31'b0, cur.mis});
                        chk_din = 1'b1;
                    end
                    scount = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        preset(32'h100, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 2'd2, 32'h100, 1'b0, $urandom, 0, 0);
        chk("tp_word_load", data_in, 32'hDEADBEEF);
        preset(32'h200, 32'h80FFFFFF);
        do_req(1'b0, 1'b0, 2'd0, 32'h203, 1'b0, $urandom, 1, 0);
        chk("tp_byte_signed", data_in, 32'hFFFFFF80);
        do_req(1'b0, 1'b0, 2'd0, 32'h203, 1'b1, $urandom, 0, 0);
        chk("tp_byte_unsigned", data_in, 32'h00000080);
        do_req(1'b1, 1'b0, 2'd1, 32'h302, 1'b0, 32'h0000ABCD, 0, 0);
        chk("tp_store_keeps_data_in", data_in, 32'h00000080);
        do_req(1'b0, 1'b0, 2'd2, 32'h100, 1'b0, $urandom, 3, 0);
        chk("tp_wait_load", data_in, 32'hDEADBEEF);
        preset(32'hFFC, 32'h11225566);
        preset(32'h1000, 32'h77883344);
        do_req(1'b0, 1'b0, 2'd2, 32'hFFE, 1'b0, $urandom, 1, 2);
`ifdef DMEM_MISALIGN_SPLIT_EN
        chk("tp_split_load", data_in, 32'h33441122);
`else
        chk("tp_misaligned_keeps", data_in, 32'hDEADBEEF);
`endif
        do_req(1'b1, 1'b1, 2'd2, 32'h104, 1'b0, 32'hCAFEF00D, 0, 0);
        do_req(1'b0, 1'b0, 2'd2, 32'h104, 1'b0, $urandom, 0, 0);
        chk("tp_both_store_wins", data_in, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] base;
            case ($urandom % 3)
                0:       base = 32'h100;
                1:       base = 32'hFF0;
                default: base = 32'hFFFFFFF0;
            endcase
            do_req(($urandom % 3) == 0, ($urandom % 4) == 0, 2'($urandom % 4),
                   base + $urandom_range(0, 15), 1'($urandom % 2), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        chk("beat_q_drained", beat_q.size(), 32'd0);
        chk("cmp_q_drained", cmp_q.size(), 32'd0);

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        slave_en = 1'b0;
        bus_ack = 1'b0;
        data_re = 1'b1;
        data_size = 2'd2;
        data_addr = 32'h100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_req && n < 10);
        if (!bus_req) fail("rst_test_no_bus0");
        chk("bus0_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_stall", {31'b0, stall}, 32'd0);
        chk("midrst_bus_req", {31'b0, bus_req}, 32'd0);
        @(posedge clk);
        #1;
        data_re = 1'b0;
        rst_n = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_ack_stall", {31'b0, stall}, 32'd0);
        chk("late_ack_bus_req", {31'b0, bus_req}, 32'd0);
        chk("midrst_data_in", data_in, 32'd0);
        chk("midrst_bus_be", {28'b0, bus_be}, 32'd0);
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored_req", {31'b0, bus_req}, 32'd0);
        chk("late_ack_ignored_din", data_in, 32'd0);
        @(posedge clk);
        #1;
        beat_q.delete();
        wait_q.delete();
        cmp_q.delete();
        have_beat = 1'b0;
        exp_din = '0;
        slave_en = 1'b1;
        mon_en = 1'b1;
        preset(32'h108, 32'h0BADF00D);
        do_req(1'b0, 1'b0, 2'd2, 32'h108, 1'b0, $urandom, 1, 0);
        chk("post_rst_load", data_in, 32'h0BADF00D);
        @(posedge clk);
        #1;
        chk("final_cmp_q_drained", cmp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
